// File: rtl/fetch_stage.sv
// Instruction fetch stage: a four-state fetch FSM with one outstanding request,
// a one-entry hold buffer for back-pressure, branch redirect with stale-response
// kill, and an IF/ID pipeline register with a consumed-instruction counter.
module fetch_stage #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // instruction memory
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  // decode back-pressure and redirect
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  // IF/ID register
  output logic             if_valid_o,
  output logic [31:0]      if_instr_o,
  output logic [XLEN-1:0]  if_pc_o,
  output logic [XLEN-1:0]  if_pc4_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_kill;
  logic             r_req;
  logic             r_if_valid;
  logic [31:0]      r_if_instr;
  logic [XLEN-1:0]  r_if_pc;
  logic [XLEN-1:0]  r_if_pc4;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hold;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_slot_free;
  logic             w_consume;
  logic             w_hold_load;

  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
  assign w_slot_free   = !r_if_valid || !stall_i;
  assign w_consume     = r_if_valid && !stall_i;
  // A response that arrives while decode is stalled parks in the hold buffer.
  assign w_hold_load   = (r_state == S_WAIT) && imem_rvalid_i && !r_kill &&
                         !redirect_i && !w_slot_free;

  // Hold buffer: captures a response that cannot enter IF/ID yet.
  // NOTE: pure data storage is left unreset; HOLD state alone says whether it is
  // meaningful, so a reset here would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_hold_load) r_hold <= imem_rdata_i;
  end

  // Fetch FSM, PC, IF/ID register and consume counter.
  // NOTE: every register here uses non-blocking assignments so all of them see
  // pre-edge values; later assignments in this block deliberately override
  // earlier ones (a data load wins over a consume-clear, a redirect wins over both).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_cnt      <= '0;
    end else begin
      r_req <= 1'b0;
      if (w_consume && !redirect_i) r_cnt <= r_cnt + CNT_W'(1);
      if (w_consume) r_if_valid <= 1'b0;

      if (redirect_i) begin
        r_pc       <= w_redirect_pc;
        r_if_valid <= 1'b0;
        unique case (r_state)
          S_IDLE, S_HOLD: begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
          S_REQ: begin
            // The request issued this cycle will return stale data.
            r_state <= S_WAIT;
            r_kill  <= 1'b1;
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_kill  <= 1'b0;
            end else begin
              r_kill  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
          S_REQ: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (r_kill) begin
                r_kill  <= 1'b0;
                r_state <= S_REQ;
                r_req   <= 1'b1;
              end else if (w_slot_free) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata_i;
                r_if_pc    <= r_pc;
                r_if_pc4   <= w_pc_plus4;
                r_pc       <= w_pc_plus4;
                r_state    <= S_REQ;
                r_req      <= 1'b1;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_slot_free) begin
              r_if_valid <= 1'b1;
              r_if_instr <= r_hold;
              r_if_pc    <= r_pc;
              r_if_pc4   <= w_pc_plus4;
              r_pc       <= w_pc_plus4;
              r_state    <= S_REQ;
              r_req      <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_pc;
  assign if_valid_o  = r_if_valid;
  assign if_instr_o  = r_if_instr;
  assign if_pc_o     = r_if_pc;
  assign if_pc4_o    = r_if_pc4;
  assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable instruction memory,
// a scoreboard queue of expected (pc, instr, pc4) per consumed instruction,
// and a bench-side model of the consume counter.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] fetch_cnt;

  fetch_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_pc4_o      (if_pc4),
    .fetch_cnt_o   (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 + a;
  endfunction

  // Instruction memory: answers each request after lat cycles.
  int unsigned lat = 1;
  int unsigned pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end
    end
    if (imem_req === 1'b1) begin
      pend_cnt  = lat;
      pend_addr = imem_addr;
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, instr: mem_word(p), pc4: p + 32'd4});
      p = p + 32'd4;
    end
  endtask

  // One clock: score any consume happening at this edge, then advance to
  // just past the edge and check the counter.
  task automatic tick();
    logic cons;
    exp_t e;
    cons = !rst && (if_valid === 1'b1) && !stall && !redirect;
    if (cons) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_pc",    if_pc,    e.pc);
        check("sb_instr", if_instr, e.instr);
        check("sb_pc4",   if_pc4,   e.pc4);
      end
      exp_cnt = exp_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    if (rst) exp_cnt = '0;
    check("fetch_cnt", fetch_cnt, exp_cnt);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && imem_req !== 1'b1; i++) tick();
    check("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset values
    repeat (3) tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc",    if_pc,    32'd0);
    check("rst_pc4",   if_pc4,   32'd0);
    check("rst_req",   {31'd0, imem_req}, 32'd0);

    // Reset release, 1-cycle memory: request two cycles after release
    push_seq(32'h0, 16);
    rst = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("first_req",  {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("wait_req",   {31'd0, imem_req}, 32'd0);
    tick();
    check("load_valid", {31'd0, if_valid}, 32'd1);
    check("load_instr", if_instr, 32'h2008_0005);
    check("load_pc",    if_pc,    32'h0);
    check("load_pc4",   if_pc4,   32'h4);
    check("next_addr",  imem_addr, 32'h4);

    // Stall for 5 cycles while the next response arrives
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_pc",    if_pc,    32'h0);
      check("stall_instr", if_instr, 32'h2008_0005);
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("held_valid", {31'd0, if_valid}, 32'd1);
    check("held_pc",    if_pc,    32'h4);
    check("held_instr", if_instr, mem_word(32'h4));
    check("held_pc4",   if_pc4,   32'h8);
    check("req_8",      imem_addr, 32'h8);

    // 3-cycle memory, redirect one cycle after the request to 0x8
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    sb.delete(); push_seq(32'h100, 16);
    tick();
    redirect = 1'b0;
    check("kill_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    check("kill_valid1", {31'd0, if_valid}, 32'd0);
    wait_req(6);
    check("redir_addr",  imem_addr, 32'h100);
    check("redir_valid", {31'd0, if_valid}, 32'd0);

    // Redirect and rvalid in the same WAIT cycle; target at the top of memory
    lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    sb.delete(); push_seq(32'hFFFF_FFFC, 16);
    tick();
    redirect = 1'b0;
    check("same_valid", {31'd0, if_valid}, 32'd0);
    check("same_req",   {31'd0, imem_req}, 32'd1);
    check("same_addr",  imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_valid", {31'd0, if_valid}, 32'd1);
    check("wrap_pc",    if_pc,    32'hFFFF_FFFC);
    check("wrap_pc4",   if_pc4,   32'h0);
    check("wrap_instr", if_instr, mem_word(32'hFFFF_FFFC));
    check("wrap_addr",  imem_addr, 32'h0);
    repeat (6) tick();

    // Second redirect while a kill is pending
    wait_req(6);
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    sb.delete(); push_seq(32'h200, 16);
    tick();
    redirect_pc = 32'h300;
    sb.delete(); push_seq(32'h300, 16);
    tick();
    redirect = 1'b0;
    wait_req(8);
    check("kill2_addr",  imem_addr, 32'h300);
    check("kill2_valid", {31'd0, if_valid}, 32'd0);

    // Reset in WAIT; stale response lands one cycle after release
    lat = 4;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst2_valid", {31'd0, if_valid}, 32'd0);
    check("rst2_instr", if_instr, 32'd0);
    check("rst2_pc",    if_pc,    32'd0);
    check("rst2_pc4",   if_pc4,   32'd0);
    check("rst2_req",   {31'd0, imem_req}, 32'd0);
    sb.delete(); push_seq(32'h0, 16);
    tick();
    check("rst2_first_req",  {31'd0, imem_req}, 32'd1);
    check("rst2_first_addr", imem_addr, 32'h0);
    lat = 1;
    tick();
    check("stale_ignored", {31'd0, if_valid}, 32'd0);
    tick();
    check("fresh_valid", {31'd0, if_valid}, 32'd1);
    check("fresh_pc",    if_pc,    32'h0);
    check("fresh_instr", if_instr, 32'h2008_0005);
    check("fresh_pc4",   if_pc4,   32'h4);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the PC, every address port and if_pc4_o.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset; it is always word-aligned.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of fetch_cnt_o.
REQ-004 clk_i  in  1  sole clock; every register updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 imem_req_o  out  1  instruction-memory request strobe, high for one cycle per request.
REQ-007 imem_addr_o  out  XLEN  request address, valid while imem_req_o=1.
REQ-008 imem_rvalid_i  in  1  read-data valid; arrives at least 1 cycle after the request.
REQ-009 imem_rdata_i  in  32  instruction word, sampled when imem_rvalid_i=1.
REQ-010 stall_i  in  1  decode cannot accept; if_* outputs hold while stall_i=1 and if_valid_o=1.
REQ-011 redirect_i  in  1  one-cycle branch/jump/jr redirect request.
REQ-012 redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
REQ-013 if_valid_o  out  1  IF/ID register holds a valid instruction.
REQ-014 if_instr_o  out  32  fetched instruction.
REQ-015 if_pc_o  out  XLEN  address of if_instr_o.
REQ-016 if_pc4_o  out  XLEN  if_pc_o+4, for jal/link writeback.
REQ-017 fetch_cnt_o  out  CNT_W  count of instructions accepted by decode.

Function
REQ-018 The block SHALL keep at most one memory request outstanding.
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT, HOLD.
- IDLE: goes to REQ on the next cycle.
- REQ: imem_req_o=1 and imem_addr_o=pc; goes to WAIT.
REQ-020 In WAIT, on imem_rvalid_i the block SHALL behave as follows:
- If kill=1: discard the data, clear kill, go to REQ.
- Else if the slot is free: load the IF/ID register, set pc<=pc+4, go to REQ.
- Else: store the data in the hold register, go to HOLD.
REQ-021 The slot SHALL be defined as free when (if_valid_o=0) or (stall_i=0).
REQ-022 HOLD SHALL wait for the slot to become free, then move the hold register into IF/ID, set pc<=pc+4 and go to REQ.
REQ-023 Decode SHALL be defined as consuming an instruction when if_valid_o=1 and stall_i=0; a consume with no new data loaded SHALL clear if_valid_o next cycle.
REQ-024 Each consume SHALL increment fetch_cnt_o by 1, wrapping modulo 2^CNT_W.
REQ-025 PC arithmetic SHALL be modulo 2^XLEN; if_pc4_o of pc=2^XLEN-4 SHALL be 0.
REQ-026 A redirect SHALL take priority over stall_i and over any data load; on redirect_i=1 in cycle t:
- pc <= {redirect_pc_i[XLEN-1:2],2'b00} at t+1.
- if_valid_o=0 at t+1 and the hold register is discarded.
- The counter does not increment for an instruction flushed in cycle t.
REQ-027 After a redirect, the next state SHALL depend on the current state:
- From IDLE or HOLD: go to REQ.
- From REQ: go to WAIT with kill=1, because the request just issued returns stale data.
- From WAIT without rvalid in the same cycle: stay in WAIT with kill=1.
- From WAIT with rvalid in the same cycle: drop the data and go to REQ.
REQ-028 A second redirect while kill=1 SHALL overwrite pc; kill stays 1.
REQ-029 With a 1-cycle memory, best-case throughput SHALL be one instruction per 2 cycles: req at t, rvalid at t+1, if_valid_o at t+2.
REQ-030 if_pc4_o SHALL be registered together with if_pc_o; it is never computed from the live pc.

Reset
REQ-031 While rst_i=1 at a clock edge, the block SHALL load:
- pc=RESET_PC, state=IDLE, kill=0.
- if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pc4_o=0.
- fetch_cnt_o=0, imem_req_o=0.
REQ-032 Reset SHALL override redirect_i and stall_i.
REQ-033 A response arriving after reset for a request issued before reset SHALL be ignored: IDLE and REQ do not sample imem_rvalid_i.
REQ-034 The first request SHALL issue in the second cycle after rst_i deasserts, with imem_addr_o=RESET_PC.

Verification
REQ-035 Reset release, 1-cycle memory returning 0x20080005, stall_i=0 -> imem_req_o with addr 0x0 two cycles after release; then if_valid_o=1, if_instr_o=0x20080005, if_pc_o=0x0, if_pc4_o=0x4; next request addr 0x4.
REQ-036 stall_i=1 for 5 cycles with if_valid_o=1 and the next response arriving -> if_* outputs unchanged and state=HOLD. On stall release: the held instruction (pc 0x4) appears next cycle and fetch_cnt_o increments once per consume.
REQ-037 3-cycle memory; redirect_i=1 with redirect_pc_i=0x103 one cycle after a request to 0x8 -> 0x8 data dropped, next request addr 0x100, and no if_valid_o for pc 0x8.
REQ-038 redirect_i and imem_rvalid_i asserted in the same cycle in WAIT -> data discarded, if_valid_o=0 next cycle, and request to the target issued next cycle.
REQ-039 XLEN=32, redirect to 0xFFFF_FFFC -> if_pc_o=0xFFFF_FFFC, if_pc4_o=0x0, and next request addr 0x0.
REQ-040 rst_i asserted while in WAIT, with rvalid arriving 1 cycle after reset release -> response ignored, outputs at reset values, and fresh request to RESET_PC.
